// File: rtl/mem_alu_sequencer.sv
// Memory-to-memory ALU micro-sequencer: reads up to two operands from the data
// memory, applies ADD/SUB/AND/MOV and writes the result back to a destination word.
module mem_alu_sequencer #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [1:0]    OP,
    input  logic [AW-1:0] SRC_A,
    input  logic [AW-1:0] SRC_B,
    input  logic [AW-1:0] DST,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] RESULT,
    output logic          CARRY,
    output logic          ZERO,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_WR,
    output logic [DW-1:0] MEM_DIN,
    input  logic [DW-1:0] MEM_DOUT
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    op_q;
    logic [AW-1:0] src_a_q, src_b_q, dst_q;
    logic [DW-1:0] reg_a_q, reg_b_q, result_q;
    logic          carry_q, zero_q;

    logic [DW:0]   sum_w, diff_w;
    logic [DW-1:0] alu_res;
    logic          alu_carry;

    // Operand ALU; the extra top bit of the subtract is the unsigned borrow.
    always_comb begin
        sum_w     = {1'b0, reg_a_q} + {1'b0, reg_b_q};
        diff_w    = {1'b0, reg_a_q} - {1'b0, reg_b_q};
        alu_res   = reg_a_q;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_w[DW-1:0];
                alu_carry = sum_w[DW];
            end
            OP_SUB: begin
                alu_res   = diff_w[DW-1:0];
                alu_carry = diff_w[DW];
            end
            OP_AND:  alu_res = reg_a_q & reg_b_q;
            default: alu_res = reg_a_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_RD_A;
            S_RD_A:  state_d = (op_q == OP_MOV) ? S_WB : S_RD_B;
            S_RD_B:  state_d = S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-facing outputs depend only on state and latched command fields.
    always_comb begin
        BUSY     = 1'b0;
        DONE     = 1'b0;
        MEM_ADDR = '0;
        MEM_WR   = 1'b0;
        MEM_DIN  = '0;
        case (state_q)
            S_RD_A: begin
                BUSY     = 1'b1;
                MEM_ADDR = src_a_q;
            end
            S_RD_B: begin
                BUSY     = 1'b1;
                MEM_ADDR = src_b_q;
            end
            S_WB: begin
                BUSY     = 1'b1;
                MEM_ADDR = dst_q;
                MEM_WR   = 1'b1;
                MEM_DIN  = alu_res;
            end
            S_DONE:  DONE = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q     <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (START) begin
                    op_q    <= OP;
                    src_a_q <= SRC_A;
                    src_b_q <= SRC_B;
                    dst_q   <= DST;
                end
                S_RD_A: reg_a_q <= MEM_DOUT;
                S_RD_B: reg_b_q <= MEM_DOUT;
                S_WB: begin
                    result_q <= alu_res;
                    carry_q  <= alu_carry;
                    zero_q   <= (alu_res == '0);
                end
                default: ;
            endcase
        end
    end

    assign RESULT = result_q;
    assign CARRY  = carry_q;
    assign ZERO   = zero_q;

endmodule

// File: tb/tb_mem_alu_sequencer.sv
// Bench for mem_alu_sequencer: a 16x4 memory model plus a shadow array and
// arithmetic reference for directed and randomized commands.
module tb_mem_alu_sequencer;

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 4;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    logic          CLK   = 1'b0;
    logic          RST   = 1'b1;
    logic          START = 1'b0;
    logic [1:0]    OP    = '0;
    logic [AW-1:0] SRC_A = '0;
    logic [AW-1:0] SRC_B = '0;
    logic [AW-1:0] DST   = '0;
    logic          BUSY, DONE, CARRY, ZERO, MEM_WR;
    logic [DW-1:0] RESULT, MEM_DIN, MEM_DOUT;
    logic [AW-1:0] MEM_ADDR;

    logic [DW-1:0] mem     [16];
    logic [DW-1:0] ref_mem [16];
    logic          pl_we   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    mem_alu_sequencer #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP),
        .SRC_A(SRC_A), .SRC_B(SRC_B), .DST(DST),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .CARRY(CARRY), .ZERO(ZERO),
        .MEM_ADDR(MEM_ADDR), .MEM_WR(MEM_WR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    always #5 CLK = ~CLK;

    // Data memory: asynchronous read, synchronous write; bench preload port shares the write.
    assign MEM_DOUT = mem[MEM_ADDR];
    always @(posedge CLK) begin
        if (MEM_WR)     mem[MEM_ADDR] <= MEM_DIN;
        else if (pl_we) mem[pl_addr]  <= pl_data;
    end

    function automatic void alu_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                      output logic [3:0] r, output logic c);
        int ai = int'(a);
        int bi = int'(b);
        c = 1'b0;
        case (op)
            OP_ADD: begin r = 4'((ai + bi) % 16); c = (ai + bi) >= 16; end
            OP_SUB: begin r = 4'((ai - bi + 16) % 16); c = ai < bi; end
            OP_AND: r = a & b;
            default: r = a;
        endcase
    endfunction

    task automatic poke(input logic [3:0] a, input logic [3:0] d);
        @(negedge CLK);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge CLK);
        pl_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // One command with per-cycle checks of the memory-facing outputs and final state.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] d, input bit hold_start);
        logic [3:0]  exp_res;
        logic        exp_c;
        logic [10:0] got, exp;
        int          exp_wb, exp_done;
        alu_model(op, ref_mem[a], ref_mem[b], exp_res, exp_c);
        exp_wb   = (op == OP_MOV) ? 2 : 3;
        exp_done = exp_wb + 1;
        @(negedge CLK);
        START = 1'b1; OP = op; SRC_A = a; SRC_B = b; DST = d;
        @(posedge CLK); #1;
        START = hold_start;
        OP = 2'($urandom); SRC_A = 4'($urandom); SRC_B = 4'($urandom); DST = 4'($urandom);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (cyc > exp_done) START = 1'b0;
            if (cyc == 1)                       exp = {3'b100, a, 4'h0};
            else if (cyc == exp_wb)             exp = {3'b101, d, exp_res};
            else if (cyc == 2)                  exp = {3'b100, b, 4'h0};
            else if (cyc == exp_done)           exp = {3'b010, 4'h0, 4'h0};
            else                                exp = '0;
            got = {BUSY, DONE, MEM_WR, MEM_ADDR, MEM_DIN};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL cmd_cycle%0d op=%0d: {busy,done,wr,addr,din} got %h want %h", cyc, op, got, exp);
            end
            if (cyc == exp_done) begin
                n_cmp++;
                if ({RESULT, CARRY, ZERO} !== {exp_res, exp_c, exp_res == 4'h0}) begin
                    n_err++;
                    $display("FAIL cmd_flags op=%0d: {res,c,z} got %h/%b/%b want %h/%b/%b",
                             op, RESULT, CARRY, ZERO, exp_res, exp_c, exp_res == 4'h0);
                end
            end
            @(posedge CLK); #1;
        end
        START = 1'b0;
        ref_mem[d] = exp_res;
        n_cmp++;
        if (mem[d] !== exp_res || RESULT !== exp_res) begin
            n_err++;
            $display("FAIL cmd_mem op=%0d: mem[%0d]=%h result=%h want %h", op, d, mem[d], RESULT, exp_res);
        end
    endtask

    task automatic test_reset();
        START = 1'b1; OP = OP_ADD; SRC_A = 4'h3; SRC_B = 4'h5; DST = 4'h7;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if ({BUSY, DONE, MEM_WR, MEM_ADDR, MEM_DIN, RESULT, CARRY, ZERO} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {BUSY, DONE, MEM_WR, MEM_ADDR, MEM_DIN, RESULT, CARRY, ZERO});
        end
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        for (int i = 0; i < 16; i++) poke(4'(i), 4'h0);
    endtask

    task automatic test_add();
        poke(4'd0, 4'd2); poke(4'd1, 4'd3); poke(4'd2, 4'd0);
        run_cmd(OP_ADD, 4'd0, 4'd1, 4'd2, 1'b0);
        n_cmp++;
        if ({mem[2], RESULT, CARRY, ZERO} !== {4'd5, 4'd5, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL add_basic: mem=%h res=%h c=%b z=%b want 5 5 0 0", mem[2], RESULT, CARRY, ZERO);
        end
    endtask

    task automatic test_sub();
        run_cmd(OP_SUB, 4'd0, 4'd1, 4'd3, 1'b0);
        n_cmp++;
        if ({mem[3], CARRY, ZERO} !== {4'hF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL sub_borrow: mem=%h c=%b z=%b want f 1 0", mem[3], CARRY, ZERO);
        end
        run_cmd(OP_SUB, 4'd1, 4'd1, 4'd3, 1'b0);
        n_cmp++;
        if ({mem[3], CARRY, ZERO} !== {4'h0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sub_zero: mem=%h c=%b z=%b want 0 0 1", mem[3], CARRY, ZERO);
        end
    endtask

    task automatic test_wrap();
        poke(4'd4, 4'hF); poke(4'd5, 4'h1);
        run_cmd(OP_ADD, 4'd4, 4'd5, 4'd4, 1'b0);
        n_cmp++;
        if ({mem[4], CARRY, ZERO} !== {4'h0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL add_wrap_alias: mem=%h c=%b z=%b want 0 1 1", mem[4], CARRY, ZERO);
        end
    endtask

    task automatic test_mov();
        run_cmd(OP_MOV, 4'd1, 4'd9, 4'd6, 1'b1);
        n_cmp++;
        if ({mem[6], CARRY} !== {4'd3, 1'b0}) begin
            n_err++;
            $display("FAIL mov_basic: mem=%h c=%b want 3 0", mem[6], CARRY);
        end
    endtask

    task automatic test_reset_abort();
        int wr_seen = 0;
        poke(4'd10, 4'd7);
        @(negedge CLK);
        START = 1'b1; OP = OP_ADD; SRC_A = 4'd0; SRC_B = 4'd1; DST = 4'd10;
        @(posedge CLK); #1;
        START = 1'b0;
        if (MEM_WR) wr_seen++;
        @(posedge CLK); #1;
        n_cmp++;
        if (MEM_ADDR !== 4'd1 || BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL abort_in_rd_b: addr=%h busy=%b want 1 1", MEM_ADDR, BUSY);
        end
        if (MEM_WR) wr_seen++;
        RST = 1'b1;
        @(posedge CLK); #1;
        n_cmp++;
        if ({BUSY, DONE, MEM_WR, MEM_ADDR, MEM_DIN, RESULT, CARRY, ZERO} !== 19'h0) begin
            n_err++;
            $display("FAIL abort_outputs: got %h want 0",
                     {BUSY, DONE, MEM_WR, MEM_ADDR, MEM_DIN, RESULT, CARRY, ZERO});
        end
        RST = 1'b0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (MEM_WR || BUSY) wr_seen++;
        end
        n_cmp++;
        if (wr_seen != 0 || mem[10] !== 4'd7) begin
            n_err++;
            $display("FAIL abort_no_write: activity=%0d mem=%h want 0 7", wr_seen, mem[10]);
        end
    endtask

    task automatic test_back_to_back();
        int done_cyc[$];
        int n_wr = 0;
        poke(4'd0, 4'd2); poke(4'd1, 4'd3);
        @(negedge CLK);
        START = 1'b1; OP = OP_AND; SRC_A = 4'd0; SRC_B = 4'd1; DST = 4'd7;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (DONE) done_cyc.push_back(cyc);
            if (MEM_WR) n_wr++;
            if (cyc == 5) begin
                START = 1'b1; OP = OP_ADD; SRC_A = 4'd0; SRC_B = 4'd1; DST = 4'd8;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
        end
        ref_mem[7] = 4'd2;
        ref_mem[8] = 4'd5;
        n_cmp++;
        if (done_cyc.size() != 2 || n_wr != 2) begin
            n_err++;
            $display("FAIL b2b_counts: dones=%0d writes=%0d want 2 2", done_cyc.size(), n_wr);
        end else begin
            n_cmp++;
            if (done_cyc[0] != 4 || done_cyc[1] - done_cyc[0] != 5) begin
                n_err++;
                $display("FAIL b2b_spacing: done at %0d,%0d want 4,9", done_cyc[0], done_cyc[1]);
            end
        end
        n_cmp++;
        if ({mem[7], mem[8]} !== {4'd2, 4'd5}) begin
            n_err++;
            $display("FAIL b2b_mem: mem7=%h mem8=%h want 2 5", mem[7], mem[8]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) poke(4'($urandom), 4'($urandom));
            run_cmd(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_wrap();
        test_mov();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run time limit reached, compared=%0d", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
